// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// No logic; consumed by div_control and seq_divider.
// Not applicable (package only).
package div_pkg;

    localparam int WIDTH = 8;
    localparam int ITER  = WIDTH;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        TRIAL = 3'd3,
        HOLD  = 3'd4
    } state_t;

endpackage

// File: rtl/div_control.sv
// Sequencer for the restoring divider: FSM plus iteration counter.
// LOAD->SHIFT/TRIAL x ITER->HOLD; zero divisor short-cuts LOAD->HOLD.
// HOLD waits for run low; run falling while busy is ignored.
module div_control
    import div_pkg::*;
#(
    parameter int ITER = div_pkg::ITER
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_div_zero,
    output logic o_ld,
    output logic o_shift,
    output logic o_trial,
    output logic o_hold,
    output logic o_busy,
    output logic o_done
);

    localparam int CT_W = $clog2(ITER) + 1;

    state_t           r_state;
    state_t           w_next;
    logic [CT_W-1:0]  r_ct;
    logic             w_last;

    assign w_last = (r_ct == CT_W'(ITER - 1));

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Iteration counter: cleared outside the loop, bumped once per trial
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ct <= '0;
        end else if (r_state == IDLE || r_state == LOAD) begin
            r_ct <= '0;
        end else if (r_state == TRIAL) begin
            r_ct <= r_ct + CT_W'(1);
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_run) w_next = LOAD;
            LOAD:    w_next = i_div_zero ? HOLD : SHIFT;
            SHIFT:   w_next = TRIAL;
            TRIAL:   w_next = w_last ? HOLD : SHIFT;
            HOLD:    if (!i_run) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Moore output decode
    always_comb begin
        o_ld    = (r_state == LOAD);
        o_shift = (r_state == SHIFT);
        o_trial = (r_state == TRIAL);
        o_hold  = (r_state == HOLD);
        o_busy  = (r_state == LOAD) || (r_state == SHIFT) || (r_state == TRIAL);
        o_done  = (r_state == HOLD);
    end

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider: Quot = Dividend / Divisor, Rem = Dividend mod Divisor.
// Result after 2*WIDTH+2 edges from Run sampled in IDLE (2 edges for Divisor=0).
// Operands sampled only in LOAD; result held in HOLD until Run drops.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = div_pkg::WIDTH
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Run,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quot,
    output logic [WIDTH-1:0] Rem,
    output logic             Busy,
    output logic             Done,
    output logic             Div_Zero
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH:0]   r_r;      // one extra bit: shifted remainder can reach 2*D-1
    logic [WIDTH-1:0] r_d;
    logic             r_div_zero;

    logic             w_ld;
    logic             w_shift;
    logic             w_trial;
    logic             w_hold;
    logic             w_div_zero;
    logic [WIDTH+1:0] w_diff;
    logic             w_borrow;

    assign w_div_zero = (Divisor == '0);
    assign w_diff     = {1'b0, r_r} - {2'b00, r_d};
    assign w_borrow   = w_diff[WIDTH+1];

    div_control #(
        .ITER (WIDTH)
    ) u_ctrl (
        .i_clk      (Clk),
        .i_rst_n    (Reset_n),
        .i_run      (Run),
        .i_div_zero (w_div_zero),
        .o_ld       (w_ld),
        .o_shift    (w_shift),
        .o_trial    (w_trial),
        .o_hold     (w_hold),
        .o_busy     (Busy),
        .o_done     (Done)
    );

    // Datapath: load operands, shift {R,Q}, then trial-subtract and restore on borrow
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_q        <= '0;
            r_r        <= '0;
            r_d        <= '0;
            r_div_zero <= 1'b0;
        end else if (w_ld) begin
            r_d        <= Divisor;
            r_div_zero <= w_div_zero;
            if (w_div_zero) begin
                r_q <= '1;
                r_r <= {1'b0, Dividend};
            end else begin
                r_q <= Dividend;
                r_r <= '0;
            end
        end else if (w_shift) begin
            {r_r, r_q} <= {r_r[WIDTH-1:0], r_q, 1'b0};
        end else if (w_trial) begin
            if (!w_borrow) begin
                r_r <= w_diff[WIDTH:0];
            end
            r_q[0] <= !w_borrow;
        end else if (w_hold) begin
            r_q        <= r_q;
            r_r        <= r_r;
            r_div_zero <= r_div_zero;
        end
    end

    assign Quot     = r_q;
    assign Rem      = r_r[WIDTH-1:0];
    assign Div_Zero = r_div_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table plus hand-written corner sequences.
// Inputs driven and outputs sampled on the falling clock edge.
// All waits on the DUT are bounded by a cycle budget.
module tb_seq_divider;

    logic       Clk;
    logic       Reset_n;
    logic       Run;
    logic [7:0] Dividend;
    logic [7:0] Divisor;
    logic [7:0] Quot;
    logic [7:0] Rem;
    logic       Busy;
    logic       Done;
    logic       Div_Zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.WIDTH(8)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Run      (Run),
        .Dividend (Dividend),
        .Divisor  (Divisor),
        .Quot     (Quot),
        .Rem      (Rem),
        .Busy     (Busy),
        .Done     (Done),
        .Div_Zero (Div_Zero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_q;
        logic [7:0] exp_r;
        logic       exp_dz;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Start an operation and wait for Done; optionally drop Run after cycle drop_at
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int drop_at,
                         output int done_at, output int busy_cnt);
        logic overlap;
        overlap  = 1'b0;
        done_at  = -1;
        busy_cnt = 0;
        Dividend = a;
        Divisor  = b;
        Run      = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (Busy) busy_cnt++;
            if (Busy && Done) overlap = 1'b1;
            if (Done) begin
                done_at = i;
                break;
            end
            if (i == drop_at) Run = 1'b0;
            // scramble operands once loaded: must not affect the result
            if (i == 1) begin
                Dividend = ~a;
                Divisor  = b ^ 8'h5A;
            end
        end
        chk("busy_done_exclusive", {31'd0, overlap}, 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        int   done_at;
        int   busy_cnt;
        logic stable;

        vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
        vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
        vecs[2] = '{8'd255, 8'd128, 8'd1,   8'd127, 1'b0};
        vecs[3] = '{8'd7,   8'd200, 8'd0,   8'd7,   1'b0};
        vecs[4] = '{8'd5,   8'd0,   8'hFF,  8'd5,   1'b1};
        vecs[5] = '{8'd200, 8'd3,   8'd66,  8'd2,   1'b0};
        vecs[6] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
        vecs[7] = '{8'd1,   8'd0,   8'hFF,  8'd1,   1'b1};

        Reset_n  = 1'b0;
        Run      = 1'b0;
        Dividend = 8'd0;
        Divisor  = 8'd0;
        #2;
        chk("reset_quot", {24'd0, Quot}, 32'd0);
        chk("reset_rem",  {24'd0, Rem},  32'd0);
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_done", {31'd0, Done}, 32'd0);
        chk("reset_dz",   {31'd0, Div_Zero}, 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("idle_no_run", {30'd0, Busy, Done}, 32'd0);

        // Table-driven operations
        for (int k = 0; k < 8; k++) begin
            do_op(vecs[k].a, vecs[k].b, -1, done_at, busy_cnt);
            chk($sformatf("v%0d_latency", k), done_at, vecs[k].exp_dz ? 32'd1 : 32'd17);
            chk($sformatf("v%0d_busy_cycles", k), busy_cnt, vecs[k].exp_dz ? 32'd1 : 32'd17);
            chk($sformatf("v%0d_quot", k), {24'd0, Quot}, {24'd0, vecs[k].exp_q});
            chk($sformatf("v%0d_rem", k), {24'd0, Rem}, {24'd0, vecs[k].exp_r});
            chk($sformatf("v%0d_dz", k), {31'd0, Div_Zero}, {31'd0, vecs[k].exp_dz});
            Run = 1'b0;
            @(negedge Clk);
            chk($sformatf("v%0d_idle", k), {30'd0, Busy, Done}, 32'd0);
            chk($sformatf("v%0d_quot_kept", k), {24'd0, Quot}, {24'd0, vecs[k].exp_q});
            chk($sformatf("v%0d_rem_kept", k), {24'd0, Rem}, {24'd0, vecs[k].exp_r});
            @(negedge Clk);
        end

        // Run held high in HOLD for 50 cycles: no restart, outputs frozen
        do_op(8'd100, 8'd7, -1, done_at, busy_cnt);
        chk("hold_latency", done_at, 32'd17);
        stable = 1'b1;
        Dividend = 8'd9;
        Divisor  = 8'd2;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (!Done || Busy || Quot !== 8'd14 || Rem !== 8'd2 || Div_Zero !== 1'b0)
                stable = 1'b0;
        end
        chk("hold_stable_50", {31'd0, stable}, 32'd1);
        Run = 1'b0;
        @(negedge Clk);
        chk("hold_exit_idle", {30'd0, Busy, Done}, 32'd0);
        chk("hold_exit_quot", {24'd0, Quot}, 32'd14);
        chk("hold_exit_rem",  {24'd0, Rem},  32'd2);
        @(negedge Clk);

        // Leave Div_Zero set, then reset in the 5th TRIAL of 200/3
        do_op(8'd5, 8'd0, -1, done_at, busy_cnt);
        chk("pre_reset_dz", {31'd0, Div_Zero}, 32'd1);
        Run = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Dividend = 8'd200;
        Divisor  = 8'd3;
        Run      = 1'b1;
        for (int i = 0; i <= 10; i++) @(negedge Clk);   // after edge 10 = 5th TRIAL
        chk("mid_op_busy", {31'd0, Busy}, 32'd1);
        Reset_n = 1'b0;
        Run     = 1'b0;
        #1;
        chk("areset_quot", {24'd0, Quot}, 32'd0);
        chk("areset_rem",  {24'd0, Rem},  32'd0);
        chk("areset_state", {30'd0, Busy, Done}, 32'd0);
        chk("areset_dz",   {31'd0, Div_Zero}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("post_reset_idle", {30'd0, Busy, Done}, 32'd0);
        do_op(8'd200, 8'd3, -1, done_at, busy_cnt);
        chk("rerun_latency", done_at, 32'd17);
        chk("rerun_quot", {24'd0, Quot}, 32'd66);
        chk("rerun_rem",  {24'd0, Rem},  32'd2);
        Run = 1'b0;
        @(negedge Clk);
        @(negedge Clk);

        // Run dropped in the 3rd SHIFT (after edge 5): completes, one HOLD cycle, IDLE
        do_op(8'd100, 8'd7, 5, done_at, busy_cnt);
        chk("drop_latency", done_at, 32'd17);
        chk("drop_quot", {24'd0, Quot}, 32'd14);
        chk("drop_rem",  {24'd0, Rem},  32'd2);
        @(negedge Clk);
        chk("drop_done_one_cycle", {30'd0, Busy, Done}, 32'd0);
        @(negedge Clk);
        chk("drop_stays_idle", {30'd0, Busy, Done}, 32'd0);
        chk("drop_quot_kept", {24'd0, Quot}, 32'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have port Clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset_n, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port Run, input, 1, start request, level-sensitive, held high by operator.
REQ-004 SHALL have port Dividend, input, 8, unsigned dividend, sampled in LOAD only.
REQ-005 SHALL have port Divisor, input, 8, unsigned divisor, sampled in LOAD only.
REQ-006 SHALL have port Quot, output, 8, quotient register; valid while Done=1.
REQ-007 SHALL have port Rem, output, 8, remainder, the low 8 bits of the 9-bit remainder register; valid while Done=1.
REQ-008 SHALL have port Busy, output, 1, high in LOAD, SHIFT and TRIAL.
REQ-009 SHALL have port Done, output, 1, high in HOLD only.
REQ-010 SHALL have port Div_Zero, output, 1, registered flag; high when the last operation had Divisor=0.
REQ-011 SHALL have parameter WIDTH, default 8, operand width; all widths derive from it.

Function
REQ-012 SHALL implement unsigned restoring division, Quot = Dividend / Divisor and Rem = Dividend mod Divisor.
REQ-013 SHALL use FSM states IDLE, LOAD, SHIFT, TRIAL, HOLD.
REQ-014 In IDLE, SHALL go to LOAD when Run=1; otherwise SHALL stay in IDLE.
REQ-015 LOAD SHALL set Q<=Dividend, D<=Divisor, R<=0, ct<=0 and Div_Zero<=(Divisor==0).
REQ-016 If Divisor=0, LOAD SHALL go directly to HOLD with Q<=8'hFF and R<=Dividend; otherwise it SHALL go to SHIFT.
REQ-017 SHIFT SHALL update {R,Q} <= {R,Q} << 1 (9+8 bits, zero fill) and then go to TRIAL.
REQ-018 TRIAL SHALL form diff = R - {0,D} at 10 bits; on no borrow, R<=diff[8:0] and Q[0]<=1; on borrow, R is unchanged and Q[0]<=0.
REQ-019 TRIAL SHALL increment ct; if ct was 7 it SHALL go to HOLD, otherwise to SHIFT.
REQ-020 ct SHALL be 4 bits, SHALL never exceed 8, and SHALL be cleared in LOAD and IDLE.
REQ-021 HOLD SHALL keep Q, R and Div_Zero frozen; it SHALL go to IDLE when Run=0 and stay in HOLD while Run=1.
REQ-022 Timing: with Run first sampled high in IDLE at edge 0, Done SHALL be high after edge 17 for a nonzero divisor and after edge 1 for a zero divisor.
REQ-023 Run falling during LOAD, SHIFT or TRIAL SHALL be ignored; the operation SHALL complete, spend one cycle in HOLD, then return to IDLE.
REQ-024 Dividend and Divisor changes outside LOAD SHALL have no effect.
REQ-025 Busy and Done SHALL be Moore outputs decoded from state only, and SHALL never be high together.
REQ-026 Quot, Rem and Div_Zero SHALL keep their last values through IDLE until the next LOAD.
REQ-027 A new operation SHALL require Run to go low and then high again; holding Run high SHALL NOT restart the divider.

Reset
REQ-028 Reset_n=0 SHALL immediately force state=IDLE, Q=0, R=0, D=0, ct=0 and Div_Zero=0, with Busy=0 and Done=0.
REQ-029 Reset asserted mid-operation SHALL abort it with no partial result retained.
REQ-030 After Reset_n deassertion, the first operation SHALL start only on Run=1 sampled in IDLE.

Structure
REQ-031 Package div_pkg SHALL hold the state enum type (IDLE, LOAD, SHIFT, TRIAL, HOLD), WIDTH, and the iteration count constant ITER=WIDTH.
REQ-032 The design SHALL be split into sub-module div_control (FSM plus ct; outputs ld, shift, trial, hold, Busy, Done) and a datapath in seq_divider holding the Q, R and D registers and the subtractor.
REQ-033 The only arithmetic SHALL be a single 10-bit subtractor; no divide operator or multiplier SHALL be used.

Verification
REQ-034 Run=1 with 100 / 7: Busy is high for 17 cycles, then Done=1, Quot=14, Rem=2, Div_Zero=0.
REQ-035 Run=1 with 255 / 1 gives Quot=255, Rem=0; then 255 / 128 gives Quot=1, Rem=127, exercising the 9th remainder bit.
REQ-036 Run=1 with 7 / 200 gives Quot=0, Rem=7; then 5 / 0 gives Done=1 one edge after LOAD, Div_Zero=1, Quot=8'hFF, Rem=5.
REQ-037 Run held high for 50 cycles after Done: the bench stays in HOLD with outputs stable; Run=0 returns to IDLE next edge, and outputs are retained.
REQ-038 Reset_n pulsed low during the 5th TRIAL of 200 / 3: outputs go to 0 asynchronously and state is IDLE; a rerun gives Quot=66, Rem=2.
REQ-039 Run dropped in the 3rd SHIFT of 100 / 7: the operation completes with Quot=14, Rem=2, Done is high for exactly one cycle, then IDLE.
